// File: rtl/tdc_merge_pkg.sv
// Shared state encoding, output-word geometry and field offsets for the TDC merger.
// Optional timestamp field is compiled in with TDC_MERGE_TS_EN.
package tdc_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PEND   = 2'd2,
        ST_DONE   = 2'd3
    } ch_state_e;

`ifdef TDC_MERGE_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Code fields inside a channel capture, in units of DEC_W from the LSB.
    localparam int FLD_FALL      = 0;
    localparam int FLD_START     = 1;
    localparam int FLD_COARSE    = 2;
    localparam int NUM_CODE_FLDS = 3;

    localparam int SETTLE_CNT_W  = 8;

    function automatic int ch_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    function automatic int code_w(input int dec_w);
        return NUM_CODE_FLDS * dec_w;
    endfunction

    function automatic int fld_lsb(input int fld, input int dec_w);
        return fld * dec_w;
    endfunction

    function automatic int ts_w_eff(input int ts_w);
        return TS_EN ? ts_w : 0;
    endfunction

    function automatic int ch_lsb(input int dec_w, input int ts_w);
        return code_w(dec_w) + ts_w_eff(ts_w);
    endfunction

    function automatic int out_w(input int nch, input int dec_w, input int ts_w);
        return ch_lsb(dec_w, ts_w) + ch_w(nch);
    endfunction

endpackage

// File: rtl/tdc_merge_ch.sv
// One TDC channel: hit synchronizer + edge detect, settle/capture FSM, sticky overflow.
// With TDC_MERGE_TS_EN the shared timestamp is captured alongside the codes.
module tdc_merge_ch
    import tdc_merge_pkg::*;
#(
    parameter int DEC_W      = 6,
`ifdef TDC_MERGE_TS_EN
    parameter int TS_W       = 16,
`endif
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hit,
    input  logic [DEC_W-1:0]     fall_code,
    input  logic [DEC_W-1:0]     start_code,
    input  logic [DEC_W-1:0]     coarse_code,
`ifdef TDC_MERGE_TS_EN
    input  logic [TS_W-1:0]      ts,
    output logic [TS_W-1:0]      cap_ts,
`endif
    input  logic                 gnt,
    input  logic                 clr_ovf,
    output logic                 req,
    output logic [3*DEC_W-1:0]   cap_code,
    output logic                 done,
    output logic                 ovf
);

    localparam logic [SETTLE_CNT_W-1:0] CNT_LAST = SETTLE_CNT_W'(SETTLE_CYC - 1);

    logic [2:0]               sync_q, sync_d;
    ch_state_e                state_q, state_d;
    logic [SETTLE_CNT_W-1:0]  cnt_q, cnt_d;
    logic [3*DEC_W-1:0]       cap_q, cap_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic                     hit_ev;
`ifdef TDC_MERGE_TS_EN
    logic [TS_W-1:0]          ts_cap_q, ts_cap_d;
`endif

    always_comb begin
        // sync_q[0..1] is the two-stage synchronizer, sync_q[2] the edge history.
        sync_d  = {sync_q[1:0], hit};
        hit_ev  = sync_q[1] & ~sync_q[2];
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        done_d  = 1'b0;
`ifdef TDC_MERGE_TS_EN
        ts_cap_d = ts_cap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hit_ev) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cap_d[fld_lsb(FLD_FALL, DEC_W)   +: DEC_W] = fall_code;
                    cap_d[fld_lsb(FLD_START, DEC_W)  +: DEC_W] = start_code;
                    cap_d[fld_lsb(FLD_COARSE, DEC_W) +: DEC_W] = coarse_code;
`ifdef TDC_MERGE_TS_EN
                    ts_cap_d = ts;
`endif
                    state_d = ST_PEND;
                end else begin
                    cnt_d = cnt_q + SETTLE_CNT_W'(1);
                end
            end
            ST_PEND: begin
                if (gnt) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A hit arriving while busy is dropped; recording it beats a clear.
        if (hit_ev && (state_q != ST_IDLE)) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cap_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef TDC_MERGE_TS_EN
            ts_cap_q <= '0;
`endif
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
`ifdef TDC_MERGE_TS_EN
            ts_cap_q <= ts_cap_d;
`endif
        end
    end

    assign req      = (state_q == ST_PEND);
    assign cap_code = cap_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
`ifdef TDC_MERGE_TS_EN
    assign cap_ts   = ts_cap_q;
`endif

endmodule

// File: rtl/tdc_merge_mc.sv
// Multi-channel TDC merger: NCH channel front-ends, round-robin arbiter and one output register.
// Defining TDC_MERGE_TS_EN adds a free-running timestamp field after ch_id.
module tdc_merge_mc
    import tdc_merge_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DEC_W      = 6,
    parameter int SETTLE_CYC = 4,
    parameter int TS_W       = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NCH-1:0]                         hit,
    input  logic [NCH*DEC_W-1:0]                   fall_code,
    input  logic [NCH*DEC_W-1:0]                   start_code,
    input  logic [NCH*DEC_W-1:0]                   coarse_code,
    output logic [out_w(NCH, DEC_W, TS_W)-1:0]     m_data,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [NCH-1:0]                         done,
    output logic [NCH-1:0]                         ovf,
    input  logic                                   clr_ovf
);

    localparam int CH_W   = ch_w(NCH);
    localparam int OUT_W  = out_w(NCH, DEC_W, TS_W);
    localparam int CODE_W = code_w(DEC_W);
    localparam int CH_LSB = ch_lsb(DEC_W, TS_W);

    logic [NCH-1:0]     req;
    logic [NCH-1:0]     gnt;
    logic [CODE_W-1:0]  cap_code [NCH];
    logic               gnt_any;
    logic [CH_W-1:0]    gnt_idx;
    logic               out_en;

    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic [OUT_W-1:0]   m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;

`ifdef TDC_MERGE_TS_EN
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [TS_W-1:0]    cap_ts [NCH];

    assign ts_d = ts_q + TS_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_d;
    end
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tdc_merge_ch #(
            .DEC_W      (DEC_W),
`ifdef TDC_MERGE_TS_EN
            .TS_W       (TS_W),
`endif
            .SETTLE_CYC (SETTLE_CYC)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .hit         (hit[i]),
            .fall_code   (fall_code[i*DEC_W +: DEC_W]),
            .start_code  (start_code[i*DEC_W +: DEC_W]),
            .coarse_code (coarse_code[i*DEC_W +: DEC_W]),
`ifdef TDC_MERGE_TS_EN
            .ts          (ts_q),
            .cap_ts      (cap_ts[i]),
`endif
            .gnt         (gnt[i]),
            .clr_ovf     (clr_ovf),
            .req         (req[i]),
            .cap_code    (cap_code[i]),
            .done        (done[i]),
            .ovf         (ovf[i])
        );
    end

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        int s;
        s = off + int'(base);
        if (s >= NCH) s = s - NCH;
        return CH_W'(s);
    endfunction

    // Search starts one past the last grant so every pending channel is reached within NCH grants.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        for (int off = 1; off <= NCH; off++) begin
            if (!gnt_any && req[rr_idx(ptr_q, off)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(ptr_q, off);
            end
        end
    end

    assign out_en = !m_valid_q || m_ready;
    assign gnt    = (out_en && gnt_any) ? (NCH'(1) << gnt_idx) : '0;

    always_comb begin
        ptr_d     = ptr_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (out_en && gnt_any) begin
            m_valid_d = 1'b1;
            ptr_d     = gnt_idx;
            m_data_d  = '0;
            m_data_d[CH_LSB +: CH_W] = gnt_idx;
            m_data_d[0 +: CODE_W]    = cap_code[gnt_idx];
`ifdef TDC_MERGE_TS_EN
            m_data_d[CODE_W +: TS_W] = cap_ts[gnt_idx];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= CH_W'(NCH - 1);
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_tdc_merge_mc.sv
// Scoreboard bench for tdc_merge_mc with default parameters.
// Timestamp checks are added when TDC_MERGE_TS_EN is defined.
module tb_tdc_merge_mc;

    localparam int NCH = 4;
    localparam int DW  = 6;
    localparam int SC  = 4;
    localparam int TSW = 16;
`ifdef TDC_MERGE_TS_EN
    localparam int TSE = TSW;
`else
    localparam int TSE = 0;
`endif
    localparam int CHW = 2;
    localparam int OW  = CHW + 3*DW + TSE;
    localparam logic [OW-1:0] TS_MASK = (OW'(1) << (3*DW + TSE)) - (OW'(1) << (3*DW));

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH-1:0]      hit = '0;
    logic [NCH*DW-1:0]   fall_code = '0;
    logic [NCH*DW-1:0]   start_code = '0;
    logic [NCH*DW-1:0]   coarse_code = '0;
    logic [OW-1:0]       m_data;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic [NCH-1:0]      done;
    logic [NCH-1:0]      ovf;
    logic                clr_ovf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt [NCH];
    int xfer_cyc [$];
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] exp_w;
    logic [DW-1:0] fc [NCH];
    logic [DW-1:0] sc [NCH];
    logic [DW-1:0] cc [NCH];
`ifdef TDC_MERGE_TS_EN
    logic [TSW-1:0] ts_seen [$];
`endif

    tdc_merge_mc #(.NCH(NCH), .DEC_W(DW), .SETTLE_CYC(SC), .TS_W(TSW)) dut (
        .clk(clk), .rst(rst), .hit(hit), .fall_code(fall_code), .start_code(start_code),
        .coarse_code(coarse_code), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .done(done), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) if (done[i]) done_cnt[i]++;
            if (m_valid && m_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("word", 64'(m_data & ~TS_MASK), 64'(exp_w));
`ifdef TDC_MERGE_TS_EN
                    ts_seen.push_back(m_data[3*DW +: TSW]);
`endif
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic clr_stats();
        for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
        xfer_cyc.delete();
    endtask

    task automatic set_codes(input int ch);
        fc[ch] = DW'($urandom);
        sc[ch] = DW'($urandom);
        cc[ch] = DW'($urandom);
        fall_code[ch*DW +: DW]   = fc[ch];
        start_code[ch*DW +: DW]  = sc[ch];
        coarse_code[ch*DW +: DW] = cc[ch];
    endtask

    task automatic push_exp(input int ch);
        logic [OW-1:0] w;
        w = '0;
        w[3*DW + TSE +: CHW] = CHW'(ch);
        w[2*DW +: DW] = cc[ch];
        w[DW +: DW]   = sc[ch];
        w[0 +: DW]    = fc[ch];
        exp_q.push_back(w);
    endtask

    task automatic pulse_hits(input logic [NCH-1:0] mask);
        hit = mask;
        tick(2);
        hit = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!m_valid && n < 60) begin
            tick(1);
            n++;
        end
        if (!m_valid) chk(tag, 0, 1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) chk(tag, 1, 0);
        tick(20);
    endtask

    initial begin
        int n;
        logic [OW-1:0] held;
        for (int i = 0; i < NCH; i++) done_cnt[i] = 0;

        // Reset state
        tick(3);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);

        // Single hit on ch2: latency, fields, one done pulse
        do_reset();
        clr_stats();
        set_codes(2);
        push_exp(2);
        hit = 4'b0100;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 2) hit = '0;
            if (m_valid) break;
        end
        chk("lat_ch2", n, SC + 4);
        chk("lat_chid", m_data[3*DW + TSE +: CHW], 2);
        wait_drain("drain_ch2");
        chk("done2_cnt", done_cnt[2], 1);
        chk("done_other", done_cnt[0] + done_cnt[1] + done_cnt[3], 0);

        // All four channels in the same cycle, back-to-back drain
        do_reset();
        clr_stats();
        for (int i = 0; i < NCH; i++) begin
            set_codes(i);
            push_exp(i);
        end
        pulse_hits(4'hF);
        wait_drain("drain_all");
        chk("all_nwords", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) chk("all_b2b", xfer_cyc[3] - xfer_cyc[0], 3);
        for (int i = 0; i < NCH; i++) chk("all_done", done_cnt[i], 1);

        // Back-pressure: output held, others stay pending, then ordered drain
        do_reset();
        clr_stats();
        m_ready = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            set_codes(i);
            push_exp(i);
        end
        pulse_hits(4'hF);
        wait_valid("bp_valid");
        tick(1);
        held = m_data;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("bp_data", m_data, held);
            chk("bp_valid", m_valid, 1);
        end
        chk("bp_pend", done_cnt[1] + done_cnt[2] + done_cnt[3], 0);
        m_ready = 1'b1;
        wait_drain("drain_bp");
        chk("bp_nwords", xfer_cyc.size(), 4);
        for (int i = 0; i < NCH; i++) chk("bp_done", done_cnt[i], 1);

        // Second hit during SETTLE on ch1 -> overflow, single word
        do_reset();
        clr_stats();
        set_codes(1);
        push_exp(1);
        pulse_hits(4'b0010);
        tick(2);
        pulse_hits(4'b0010);
        wait_drain("drain_ovf");
        chk("ovf_set", ovf, 4'b0010);
        chk("ovf_nwords", xfer_cyc.size(), 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Reset while ch3 is pending behind a stalled word
        do_reset();
        clr_stats();
        m_ready = 1'b0;
        set_codes(0);
        set_codes(3);
        pulse_hits(4'b1001);
        wait_valid("rp_valid");
        tick(2);
        rst = 1'b1;
        #2;
        chk("rp_valid", m_valid, 0);
        chk("rp_data", m_data, 0);
        chk("rp_done", done, 0);
        chk("rp_ovf", ovf, 0);
        tick(2);
        rst = 1'b0;
        m_ready = 1'b1;
        tick(20);
        chk("rp_done3", done_cnt[3], 0);
        chk("rp_nwords", xfer_cyc.size(), 0);
        set_codes(3);
        push_exp(3);
        pulse_hits(4'b1000);
        wait_drain("drain_rp");
        chk("rp_after", done_cnt[3], 1);

`ifdef TDC_MERGE_TS_EN
        // Timestamp delta over 100 cycles, then again straddling the counter wrap
        for (int pass = 0; pass < 2; pass++) begin
            int h0;
            logic [TSW-1:0] d;
            do_reset();
            if (pass == 1) tick(65536 - 60);
            ts_seen.delete();
            set_codes(0);
            push_exp(0);
            push_exp(0);
            h0 = cyc;
            pulse_hits(4'b0001);
            wait_drain("drain_ts0");
            while (cyc < h0 + 100) tick(1);
            pulse_hits(4'b0001);
            wait_drain("drain_ts1");
            chk("ts_nwords", ts_seen.size(), 2);
            if (ts_seen.size() == 2) begin
                d = ts_seen[1] - ts_seen[0];
                chk("ts_delta", d, 100);
            end
        end
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tdc_merge_mc.md
TDC_MERGE_MC -- requirements
Module: tdc_merge_mc

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NCH, 4, number of TDC channels (1..16)
- DEC_W, 6, width of each decoded code field
- SETTLE_CYC, 4, clk cycles between hit detection and code capture (1..255)
- TS_W, 16, timestamp width (used only with TDC_MERGE_TS_EN)
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- hit  in  NCH  per-channel fall-edge strobe, asynchronous to clk
- fall_code  in  NCH*DEC_W  per-channel fall-edge fine code
- start_code  in  NCH*DEC_W  per-channel start-edge fine code
- coarse_code  in  NCH*DEC_W  per-channel coarse count
- m_data  out  OUT_W  merged word {ch_id, [ts,] coarse, start, fall}
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- done  out  NCH  per-channel one-cycle front-end reset pulse
- ovf  out  NCH  sticky per-channel dropped-hit flag
- clr_ovf  in  1  synchronous clear of all ovf bits
REQ-003 OUT_W SHALL equal CH_W + 3*DEC_W (+TS_W when enabled), CH_W = max(1, clog2(NCH)).

Function
REQ-004 Each hit bit SHALL pass a 2-FF synchronizer followed by rising-edge detection; a detected edge is a "hit event".
REQ-005 Each channel SHALL run FSM IDLE -> SETTLE -> PEND -> DONE -> IDLE.
REQ-006 IDLE: hit event -> SETTLE, settle counter loaded with 0.
REQ-007 SETTLE: counter increments each cycle; at count SETTLE_CYC-1 the channel's three code fields are captured into a channel register and state -> PEND.
REQ-008 PEND: channel asserts request; on grant -> DONE.
REQ-009 DONE: done[i] high for exactly one cycle; next state IDLE.
REQ-010 A hit event in SETTLE, PEND or DONE SHALL be ignored and set ovf[i]; ovf set wins over clr_ovf in the same cycle.
REQ-011 Arbiter SHALL be round-robin: search starts at index after the last-granted channel, wraps at NCH-1 -> 0; at most one grant per cycle.
REQ-012 Grant SHALL be issued only when output register empty or (m_valid and m_ready) in that cycle; m_data/m_valid load next cycle.
REQ-013 m_data SHALL remain stable while m_valid=1 and m_ready=0; sustained throughput one word per cycle.
REQ-014 Latency: hit event on cycle t -> m_valid at t+SETTLE_CYC+2 when output idle and no contention.
REQ-015 Simultaneous PEND on all channels SHALL each drain within NCH grants, no starvation.

Reset
REQ-016 rst SHALL asynchronously force all FSMs to IDLE, counters and synchronizers to 0, m_valid=0, m_data=0, done=0, ovf=0, round-robin pointer to NCH-1 (channel 0 first).
REQ-017 rst asserted mid-SETTLE or mid-PEND SHALL discard captured data with no done pulse.

Configuration
REQ-018 With TDC_MERGE_TS_EN defined, a free-running TS_W-bit counter (wraps) SHALL be sampled at capture (REQ-007) and inserted after ch_id; without it the counter and field SHALL not exist and OUT_W excludes TS_W.

Structure
REQ-019 Package tdc_merge_pkg SHALL hold channel state encoding, CH_W/OUT_W width functions and field-offset constants.
REQ-020 Per-channel synchronizer, FSM, settle counter, capture register and ovf SHALL be sub-module tdc_merge_ch, instantiated NCH times; arbiter and output register stay in top.

Verification
REQ-021 Single hit ch2, SETTLE_CYC=4, m_ready=1 -> m_valid 6 cycles after hit event, ch_id=2, fields equal codes at capture, done[2] one pulse.
REQ-022 Hits on ch0..ch3 same cycle, m_ready=1 -> four consecutive words ch0,1,2,3, four done pulses.
REQ-023 m_ready=0 for 10 cycles with word pending -> m_data stable, m_valid held, others stay PEND; release -> in-order drain.
REQ-024 Second hit ch1 during SETTLE -> ovf[1]=1, one word only; clr_ovf -> ovf[1]=0.
REQ-025 rst pulse while ch3 in PEND -> no word, no done[3], all outputs 0; new hit afterwards processed normally.
REQ-026 TDC_MERGE_TS_EN defined, two hits 100 cycles apart -> timestamp delta 100, including across counter wrap.
